// File: rtl/execute_cycle_pkg.sv
// Shared constants and encodings for the EX stage.
// Optional build macro FWD_FINAL_EN: forward select 11 picks the final write-back buffer.
package execute_cycle_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_FIN = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational 32-bit ALU for the EX stage; wrap-around arithmetic, carry discarded.
module alu
  import execute_cycle_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  always_comb begin
    Result = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_XOR: Result = A ^ B;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      // Only the low five bits of B count as shift amount.
      ALU_SLL: Result = A << B[4:0];
      ALU_SRL: Result = A >> B[4:0];
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, branch target/decision and the EX->MEM register.
// Build macro FWD_FINAL_EN enables forwarding from ResultF on select 11.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ResultF,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] srcAE, srcBFwdE, srcBE, aluResultE;
  logic            zeroE;

  logic            regWrite_q, memWrite_q, resultSrc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pcPlus4_q, writeData_q, aluResult_q;

`ifndef FWD_FINAL_EN
  logic unused_resultf;
  assign unused_resultf = ^ResultF;
`endif

  // The MEM-stage source is the registered result, so no loop forms through the ALU.
  always_comb begin
    srcAE = RD1_E;
    case (ForwardAE)
      FWD_RF:  srcAE = RD1_E;
      FWD_MEM: srcAE = aluResult_q;
      FWD_WB:  srcAE = ResultW;
`ifdef FWD_FINAL_EN
      FWD_FIN: srcAE = ResultF;
`else
      FWD_FIN: srcAE = RD1_E;
`endif
      default: srcAE = RD1_E;
    endcase
  end

  always_comb begin
    srcBFwdE = RD2_E;
    case (ForwardBE)
      FWD_RF:  srcBFwdE = RD2_E;
      FWD_MEM: srcBFwdE = aluResult_q;
      FWD_WB:  srcBFwdE = ResultW;
`ifdef FWD_FINAL_EN
      FWD_FIN: srcBFwdE = ResultF;
`else
      FWD_FIN: srcBFwdE = RD2_E;
`endif
      default: srcBFwdE = RD2_E;
    endcase
  end

  assign srcBE = ALUSrcE ? Imm_Ext_E : srcBFwdE;

  alu u_alu (
    .A          (srcAE),
    .B          (srcBE),
    .ALUControl (ALUControlE),
    .Result     (aluResultE),
    .Zero       (zeroE)
  );

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = rst & BranchE & zeroE;

  // Store data is the forwarded B operand, never the immediate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite_q  <= 1'b0;
      memWrite_q  <= 1'b0;
      resultSrc_q <= 1'b0;
      rd_q        <= '0;
      pcPlus4_q   <= '0;
      writeData_q <= '0;
      aluResult_q <= '0;
    end else begin
      regWrite_q  <= RegWriteE;
      memWrite_q  <= MemWriteE;
      resultSrc_q <= ResultSrcE;
      rd_q        <= RD_E;
      pcPlus4_q   <= PCPlus4E;
      writeData_q <= srcBFwdE;
      aluResult_q <= aluResultE;
    end
  end

  assign RegWriteM   = regWrite_q;
  assign MemWriteM   = memWrite_q;
  assign ResultSrcM  = resultSrc_q;
  assign RD_M        = rd_q;
  assign PCPlus4M    = pcPlus4_q;
  assign WriteDataM  = writeData_q;
  assign ALU_ResultM = aluResult_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle; honours FWD_FINAL_EN the same way as the design.
module tb_execute_cycle;

  logic        clk, rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, ResultF;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic        resultSrc;
    logic [4:0]  rd;
    logic [31:0] pcPlus4;
    logic [31:0] writeData;
    logic [31:0] alu;
  } m_t;

  m_t          sbq[$];
  m_t          exp, obs;
  logic [31:0] expAluM;
  int          checks = 0;
  int          errors = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW), .ResultF(ResultF),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'b10:   return expAluM;
      2'b01:   return ResultW;
`ifdef FWD_FINAL_EN
      2'b11:   return ResultF;
`endif
      default: return rf;
    endcase
  endfunction

  // Predict the M-stage contents the coming edge should register.
  task automatic push_expected();
    logic [31:0] a, bf, b;
    m_t e;
    a  = model_fwd(ForwardAE, RD1_E);
    bf = model_fwd(ForwardBE, RD2_E);
    b  = ALUSrcE ? Imm_Ext_E : bf;
    e.regWrite  = RegWriteE;
    e.memWrite  = MemWriteE;
    e.resultSrc = ResultSrcE;
    e.rd        = RD_E;
    e.pcPlus4   = PCPlus4E;
    e.writeData = bf;
    e.alu       = model_alu(ALUControlE, a, b);
    sbq.push_back(e);
    expAluM = e.alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; RegWriteE = 1'b1; ALUSrcE = 1'b0; MemWriteE = 1'b1; ResultSrcE = 1'b1;
    BranchE = 1'b0; ALUControlE = 3'b000; RD1_E = 32'd5; RD2_E = 32'd7;
    Imm_Ext_E = 32'd0; PCE = 32'h100; PCPlus4E = 32'h104; RD_E = 5'd3;
    ResultW = 32'h20; ResultF = 32'h30; ForwardAE = 2'b00; ForwardBE = 2'b00;
    expAluM = 32'd0;
    #1;
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== '0) begin errors++; $display("[TB] FAIL reset_initial: got %h expected 0", obs); end
    @(negedge clk); rst = 1'b1;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reset_capture: got %h expected %h", obs, exp); end
    // Zero-producing branch so PCSrcE would be 1 if not masked by reset.
    BranchE = 1'b1; ALUControlE = 3'b001; RD2_E = 32'd5;
    #2 rst = 1'b0;
    sbq.delete();
    expAluM = 32'd0;
    #1;
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== '0) begin errors++; $display("[TB] FAIL reset_async_clear: got %h expected 0", obs); end
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("[TB] FAIL reset_pcsrc: got %b expected 0", PCSrcE); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if ({RegWriteM, MemWriteM} !== 2'b00) begin errors++; $display("[TB] FAIL release_ctrl: got %b expected 00", {RegWriteM, MemWriteM}); end
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("[TB] FAIL release_pcsrc: got %b expected 1", PCSrcE); end
    BranchE = 1'b0;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL first_edge_after_reset: got %h expected %h", obs, exp); end
  endtask

  task automatic test_add_sub();
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;
    RD1_E = 32'd5; RD2_E = 32'd7; ALUControlE = 3'b000; RD_E = 5'd7; PCPlus4E = 32'h204;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp || ALU_ResultM !== 32'd12) begin errors++; $display("[TB] FAIL add_5_7: got %h expected %h", obs, exp); end
    ALUControlE = 3'b001;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp || ALU_ResultM !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL sub_5_7: got %h expected %h", obs, exp); end
  endtask

  task automatic test_alu_ops();
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ALUControlE = 3'(i % 8);
      RD1_E = $urandom; RD2_E = $urandom;
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
      RD_E = 5'($urandom); PCPlus4E = $urandom;
      push_expected();
      tick();
      exp = sbq.pop_front();
      obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL alu_op_%0d: got %h expected %h", ALUControlE, obs, exp); end
    end
    RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [31:0] want[3];
    logic [1:0]  sels[3];
    want[0] = 32'h10; want[1] = 32'h20;
`ifdef FWD_FINAL_EN
    want[2] = 32'h30;
`else
    want[2] = 32'h1;
`endif
    sels[0] = 2'b10; sels[1] = 2'b01; sels[2] = 2'b11;
    ResultW = 32'h20; ResultF = 32'h30; ALUControlE = 3'b000; ALUSrcE = 1'b1;
    Imm_Ext_E = 32'd0; ForwardAE = 2'b00; ForwardBE = 2'b00; RD1_E = 32'h10;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL fwd_seed: got %h expected %h", obs, exp); end
    RD1_E = 32'd1;
    for (int i = 0; i < 3; i++) begin
      ForwardAE = sels[i];
      push_expected();
      tick();
      exp = sbq.pop_front();
      obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
      checks++;
      if (obs !== exp || ALU_ResultM !== want[i]) begin errors++; $display("[TB] FAIL fwdA_%b: got %h expected %h (alu %h)", sels[i], obs, exp, want[i]); end
    end
    ForwardAE = 2'b00; ALUSrcE = 1'b0; RD2_E = 32'h5;
    for (int i = 0; i < 3; i++) begin
      ForwardBE = sels[i];
      push_expected();
      tick();
      exp = sbq.pop_front();
      obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL fwdB_%b: got %h expected %h", sels[i], obs, exp); end
    end
    ForwardBE = 2'b00;
  endtask

  task automatic test_store_forward();
    ALUSrcE = 1'b1; Imm_Ext_E = 32'd4; ForwardAE = 2'b00; ForwardBE = 2'b01;
    ResultW = 32'hDEADBEEF; RD1_E = 32'h100; RD2_E = 32'h55; MemWriteE = 1'b1;
    ALUControlE = 3'b000; RegWriteE = 1'b0;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp || WriteDataM !== 32'hDEADBEEF || ALU_ResultM !== 32'h104) begin
      errors++; $display("[TB] FAIL store_fwd_wb: got %h expected %h", obs, exp);
    end
    ForwardBE = 2'b00;
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp || WriteDataM !== 32'h55) begin errors++; $display("[TB] FAIL store_rf_not_imm: got %h expected %h", obs, exp); end
    MemWriteE = 1'b0; RegWriteE = 1'b1;
  endtask

  task automatic test_back_to_back();
    ALUSrcE = 1'b0; ForwardAE = 2'b10; ForwardBE = 2'b00; RD2_E = 32'd3; ALUControlE = 3'b000;
    for (int i = 0; i < 6; i++) begin
      push_expected();
      tick();
      exp = sbq.pop_front();
      obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
      checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL back_to_back_%0d: got %h expected %h", i, obs, exp); end
    end
    ForwardAE = 2'b00;
  endtask

  task automatic test_branch();
    BranchE = 1'b1; ALUControlE = 3'b001; ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    RD1_E = 32'd9; RD2_E = 32'd9; PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF8;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8) begin errors++; $display("[TB] FAIL branch_taken: got %b/%h expected 1/000000f8", PCSrcE, PCTargetE); end
    RD2_E = 32'd8;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("[TB] FAIL branch_not_taken: got %b expected 0", PCSrcE); end
    RD2_E = 32'd9; BranchE = 1'b0;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("[TB] FAIL branch_disabled: got %b expected 0", PCSrcE); end
    push_expected();
    tick();
    exp = sbq.pop_front();
    obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL branch_register: got %h expected %h", obs, exp); end
  endtask

  task automatic test_edge_cases();
    logic [2:0]  ops[3];
    logic [31:0] as[3], bs[3], want[3];
    ops[0] = 3'b101; as[0] = 32'h80000000; bs[0] = 32'd1;  want[0] = 32'd1;
    ops[1] = 3'b110; as[1] = 32'd1;        bs[1] = 32'd33; want[1] = 32'd2;
    ops[2] = 3'b111; as[2] = 32'h80000000; bs[2] = 32'd33; want[2] = 32'h40000000;
    ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    for (int i = 0; i < 3; i++) begin
      ALUControlE = ops[i]; RD1_E = as[i]; RD2_E = bs[i];
      push_expected();
      tick();
      exp = sbq.pop_front();
      obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};
      checks++;
      if (obs !== exp || ALU_ResultM !== want[i]) begin errors++; $display("[TB] FAIL edge_op_%0d: got %h expected %h (alu %h)", i, obs, exp, want[i]); end
    end
    PCE = 32'hFFFFFFFC; Imm_Ext_E = 32'd8;
    #1;
    checks++;
    if (PCTargetE !== 32'd4) begin errors++; $display("[TB] FAIL pctarget_wrap: got %h expected 00000004", PCTargetE); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_alu_ops();
    test_forwarding();
    test_store_forward();
    test_back_to_back();
    test_branch();
    test_edge_cases();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
